// File: rtl/perspective_divide_sequencer_pkg.sv
// Shared types and constants for the perspective-divide sequencer.
package perspective_pkg;

  localparam logic [31:0] FP32_ONE = 32'h3F800000;

  typedef logic [3:0][31:0] vertex_t;
  typedef logic [1:0]       comp_idx_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    COLLECT = 2'd2,
    OUTPUT  = 2'd3
  } pdiv_state_t;

  // Dividend for component k: x, y, z, then 1.0 so that slot 3 yields 1/w.
  function automatic logic [31:0] numerator_sel(input vertex_t v, input comp_idx_t i);
    return (i == 2'd3) ? FP32_ONE : v[i];
  endfunction

endpackage

// File: rtl/fp32_div.sv
// Pipelined IEEE fp32 divider: result appears LATENCY edges after the edge that samples valid_in.
// Denormals are flushed to zero; rounding is round-to-nearest-even.
module fp32_div #(
  parameter int LATENCY = 28
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        valid_in,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        valid_out,
  output logic [31:0] c_out
);

  logic              sign;
  logic [7:0]        ea, eb;
  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [48:0]       num, den;
  logic [25:0]       q;
  logic              rem_nz;
  logic signed [9:0] e;
  logic [22:0]       frac;
  logic              g, s;
  logic [23:0]       frac_r;
  logic [31:0]       quot;

  always_comb begin
    sign   = a[31] ^ b[31];
    ea     = a[30:23];
    eb     = b[30:23];
    a_nan  = (ea == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (eb == 8'hFF) && (b[22:0] != 23'd0);
    a_inf  = (ea == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (eb == 8'hFF) && (b[22:0] == 23'd0);
    a_zero = (ea == 8'h00);
    b_zero = (eb == 8'h00);
    num    = {1'b1, a[22:0], 25'd0};
    den    = {25'd0, 1'b1, b[22:0]};
    q      = 26'(num / den);
    rem_nz = (num % den) != 49'd0;
    // Mantissa ratio lies in (0.5, 2); q[25] tells which binade it landed in.
    if (q[25]) begin
      frac = q[24:2];
      g    = q[1];
      s    = q[0] | rem_nz;
      e    = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
    end else begin
      frac = q[23:1];
      g    = q[0];
      s    = rem_nz;
      e    = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd126;
    end
    frac_r = {1'b0, frac} + {23'd0, g & (s | frac[0])};
    if (frac_r[23]) e = e + 10'sd1;
    if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero))
      quot = 32'h7FC00000;
    else if (a_inf || b_zero)
      quot = {sign, 8'hFF, 23'd0};
    else if (a_zero || b_inf)
      quot = {sign, 31'd0};
    else if (e >= 10'sd255)
      quot = {sign, 8'hFF, 23'd0};
    else if (e <= 10'sd0)
      quot = {sign, 31'd0};
    else
      quot = {sign, e[7:0], frac_r[22:0]};
  end

  logic [LATENCY:0]       v_pipe;
  logic [LATENCY:0][31:0] d_pipe;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      v_pipe <= '0;
      d_pipe <= '0;
    end else begin
      v_pipe <= {v_pipe[LATENCY-1:0], valid_in};
      d_pipe <= {d_pipe[LATENCY-1:0], quot};
    end
  end

  assign valid_out = v_pipe[LATENCY];
  assign c_out     = d_pipe[LATENCY];

endmodule

// File: rtl/perspective_divide_sequencer.sv
// Clip->NDC perspective divide over one shared fp32_div (x/w, y/w, z/w, 1/w in turn).
// Define PDIV_CULL_EN to drop behind-eye vertices at acceptance and count them.
//
// state   | meaning
// IDLE    | ready_out=1, waiting for a vertex
// ISSUE   | feeding the divider one component per cycle (idx 0..3)
// COLLECT | writing divider results into vertex_out in arrival order
// OUTPUT  | valid_out held until downstream takes the vertex
module perspective_divide_sequencer
  import perspective_pkg::*;
#(
  parameter int DIV_LATENCY = 28,
  parameter int CULL_CNT_W  = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic [3:0][31:0] vertex_in,
  output logic             valid_out,
  input  logic             ready_in,
  output logic [3:0][31:0] vertex_out
`ifdef PDIV_CULL_EN
  ,
  output logic [CULL_CNT_W-1:0] cull_count_out
`endif
);

  pdiv_state_t state;
  comp_idx_t   idx, ridx;
  vertex_t     vin_q;
  logic        accept, do_cull;
  logic        div_valid_out;
  logic [31:0] div_a, div_c;

  assign ready_out = (state == IDLE) && !rst_in;
  assign accept    = valid_in && ready_out;

`ifdef PDIV_CULL_EN
  // Negative or zero/denormal w means the vertex is at or behind the eye.
  assign do_cull = vertex_in[3][31] || (vertex_in[3][30:23] == 8'h00);
`else
  assign do_cull = 1'b0;
`endif

  assign div_a = numerator_sel(vin_q, idx);

  fp32_div #(
    .LATENCY(DIV_LATENCY)
  ) u_div (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .valid_in (state == ISSUE),
    .a        (div_a),
    .b        (vin_q[3]),
    .valid_out(div_valid_out),
    .c_out    (div_c)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state      <= IDLE;
      idx        <= '0;
      ridx       <= '0;
      vin_q      <= '0;
      vertex_out <= '0;
      valid_out  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && !do_cull) begin
            vin_q <= vertex_in;
            idx   <= '0;
            ridx  <= '0;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          idx <= idx + 2'd1;
          if (idx == 2'd3) state <= COLLECT;
        end
        COLLECT: begin
          // Slot chosen by result count, so divider latency never needs to be known here.
          if (div_valid_out) begin
            vertex_out[ridx] <= div_c;
            ridx             <= ridx + 2'd1;
            if (ridx == 2'd3) begin
              valid_out <= 1'b1;
              state     <= OUTPUT;
            end
          end
        end
        OUTPUT: begin
          if (ready_in) begin
            valid_out <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PDIV_CULL_EN
  always_ff @(posedge clk_in) begin
    if (rst_in)
      cull_count_out <= '0;
    else if (accept && do_cull && !(&cull_count_out))
      cull_count_out <= cull_count_out + 1'b1;
  end
`endif

  a_div_result_outside_collect : assert property (
    @(posedge clk_in) disable iff (rst_in) div_valid_out |-> (state == COLLECT)
  );

endmodule

// File: tb/tb_perspective_divide_sequencer.sv
// Scoreboard bench for perspective_divide_sequencer: expected vertices are queued at issue
// and compared by a monitor at each output handshake.
module tb_perspective_divide_sequencer;
  import perspective_pkg::*;

  localparam int LAT = 28;

  logic             clk = 1'b0;
  logic             rst_in;
  logic             valid_in;
  logic             ready_out;
  logic [3:0][31:0] vertex_in;
  logic             valid_out;
  logic             ready_in;
  logic [3:0][31:0] vertex_out;
`ifdef PDIV_CULL_EN
  logic [15:0]      cull_count;
`endif

  perspective_divide_sequencer #(
    .DIV_LATENCY(LAT),
    .CULL_CNT_W (16)
  ) dut (
    .clk_in    (clk),
    .rst_in    (rst_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .vertex_in (vertex_in),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .vertex_out(vertex_out)
`ifdef PDIV_CULL_EN
    ,
    .cull_count_out(cull_count)
`endif
  );

  always #5 clk = ~clk;

  int      cyc = 0;
  int      checks = 0;
  int      errors = 0;
  int      acc_edge = 0;
  vertex_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic vertex_t mk(input logic [31:0] x, input logic [31:0] y,
                                 input logic [31:0] z, input logic [31:0] w);
    return {w, z, y, x};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timeout at cycle %0d", name, cyc);
  endtask

  // Monitor: every handshake pops one expected vertex.
  always @(negedge clk) begin
    if (!rst_in && valid_out && ready_in) begin
      if (exp_q.size() == 0) begin
        fail_timeout("unexpected_output");
      end else begin
        vertex_t e;
        e = exp_q.pop_front();
        check("vertex_out", vertex_out, e);
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send(input vertex_t v, input bit push, input vertex_t e, input bit keep_valid);
    int n;
    n = 0;
    vertex_in = v;
    valid_in  = 1'b1;
    @(negedge clk);
    while (!ready_out && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ready_out) fail_timeout("send_ready");
    if (push) exp_q.push_back(e);
    @(posedge clk);
    #1;
    acc_edge = cyc;
    valid_in = keep_valid;
  endtask

  task automatic wait_valid(output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!valid_out && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!valid_out) fail_timeout("wait_valid");
    lat = cyc - acc_edge;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) fail_timeout("drain");
    @(posedge clk);
    #1;
  endtask

  initial begin
    int      lat;
    int      acc_s[3];
    bit      seen;
    vertex_t vs[3];
    vertex_t es[3];

    rst_in    = 1'b1;
    valid_in  = 1'b0;
    ready_in  = 1'b1;
    vertex_in = '0;

    @(negedge clk);
    check("rst_ready_out", ready_out, 0);
    check("rst_valid_out", valid_out, 0);
    check("rst_vertex_out", vertex_out, 0);
    repeat (2) @(posedge clk);
    #1 rst_in = 1'b0;
    @(negedge clk);
    check("post_rst_ready_out", ready_out, 1);
    check("post_rst_valid_out", valid_out, 0);
    @(posedge clk);
    #1;

    // Basic vertex and latency
    send(mk(32'h40000000, 32'h40800000, 32'hBF800000, 32'h40000000), 1'b1,
         mk(32'h3F800000, 32'h40000000, 32'hBF000000, 32'h3F000000), 1'b0);
    wait_valid(lat);
    check("basic_latency", lat, LAT + 5);
    drain(50);

    // Backpressure
    ready_in = 1'b0;
    send(mk(32'h3F800000, 32'h40400000, 32'h40800000, 32'h40800000), 1'b1,
         mk(32'h3E800000, 32'h3F400000, 32'h3F800000, 32'h3E800000), 1'b0);
    wait_valid(lat);
    for (int i = 0; i < 10; i++) begin
      check("bp_valid_out", valid_out, 1);
      check("bp_ready_out", ready_out, 0);
      check("bp_vertex_out", vertex_out,
            mk(32'h3E800000, 32'h3F400000, 32'h3F800000, 32'h3E800000));
      @(negedge clk);
    end
    @(posedge clk);
    #1 ready_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release_valid_out", valid_out, 0);
    check("bp_release_ready_out", ready_out, 1);
    drain(10);

    // Stream with valid_in held high
    vs[0] = mk(32'hC1000000, 32'h41000000, 32'h3F000000, 32'h3F000000);
    es[0] = mk(32'hC1800000, 32'h41800000, 32'h3F800000, 32'h40000000);
    vs[1] = mk(32'h40A00000, 32'hC0400000, 32'h00000000, 32'h40000000);
    es[1] = mk(32'h40200000, 32'hBFC00000, 32'h00000000, 32'h3F000000);
    vs[2] = mk(32'h40100000, 32'h3FC00000, 32'hC0400000, 32'h3F800000);
    es[2] = mk(32'h40100000, 32'h3FC00000, 32'hC0400000, 32'h3F800000);
    for (int i = 0; i < 3; i++) begin
      send(vs[i], 1'b1, es[i], (i < 2));
      acc_s[i] = acc_edge;
    end
    drain(200);
    for (int i = 0; i < 2; i++)
      check("stream_accept_gap", acc_s[i+1] - acc_s[i] - 1, LAT + 6);

    // Reset while ISSUE has reached idx=2
    send(mk(32'h41200000, 32'h41200000, 32'h41200000, 32'h41200000), 1'b0, '0, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 rst_in = 1'b1;
    @(posedge clk);
    #1 rst_in = 1'b0;
    @(negedge clk);
    check("midrst_valid_out", valid_out, 0);
    check("midrst_vertex_out", vertex_out, 0);
    check("midrst_ready_out", ready_out, 1);
    seen = 1'b0;
    repeat (2 * LAT) begin
      @(negedge clk);
      if (valid_out) seen = 1'b1;
    end
    check("midrst_no_stale_valid", seen, 0);
    @(posedge clk);
    #1;
    send(mk(32'hC2C80000, 32'h42C80000, 32'h3E800000, 32'h40800000), 1'b1,
         mk(32'hC1C80000, 32'h41C80000, 32'h3D800000, 32'h3E800000), 1'b0);
    wait_valid(lat);
    check("midrst_recover_latency", lat, LAT + 5);
    drain(50);

`ifdef PDIV_CULL_EN
    send(mk(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'hBF800000), 1'b0, '0, 1'b0);
    @(negedge clk);
    check("cull_neg_ready_out", ready_out, 1);
    @(posedge clk);
    #1;
    send(mk(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h00000000), 1'b0, '0, 1'b0);
    @(negedge clk);
    check("cull_zero_ready_out", ready_out, 1);
    seen = 1'b0;
    repeat (LAT + 10) begin
      @(negedge clk);
      if (valid_out) seen = 1'b1;
    end
    check("cull_no_valid", seen, 0);
    check("cull_count", cull_count, 2);
    @(posedge clk);
    #1;
    send(mk(32'h40400000, 32'hC0000000, 32'h3F000000, 32'h3F800000), 1'b1,
         mk(32'h40400000, 32'hC0000000, 32'h3F000000, 32'h3F800000), 1'b0);
    drain(100);
    check("cull_count_after_pass", cull_count, 2);
`else
    // w=0 without culling: divider infinities and NaN pass straight through
    send(mk(32'h3F800000, 32'hBF800000, 32'h00000000, 32'h00000000), 1'b1,
         mk(32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h7F800000), 1'b0);
    wait_valid(lat);
    check("wzero_latency", lat, LAT + 5);
    drain(50);
    @(negedge clk);
    check("wzero_ready_after", ready_out, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
